// File: rtl/mem_fifo_ctrl.sv
// FIFO controller fronting a single-port register memory, with a registered
// output word. Memory writes and head fetches share the port round-robin.
module mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_BITS:0]    count,
  output logic                  full,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [ADDR_BITS:0] LP_DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic {
    OP_FETCH = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  op_e                   r_last_op;
  op_e                   w_last_op_nxt;
  logic [ADDR_BITS-1:0]  r_wr_ptr;
  logic [ADDR_BITS-1:0]  r_rd_ptr;
  logic [ADDR_BITS:0]    r_mem_cnt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  logic w_fetch_ok;
  logic w_in_ready;
  logic w_write;
  logic w_fetch;

  // in_ready is gated by rst_n so it drops immediately while reset is held.
  always_comb begin
    w_fetch_ok    = (r_mem_cnt != '0) && (!r_out_valid || out_ready);
    w_in_ready    = rst_n && (r_mem_cnt < LP_DEPTH)
                    && !(w_fetch_ok && (r_last_op == OP_WRITE));
    w_write       = in_valid && w_in_ready;
    w_fetch       = w_fetch_ok && !w_write;
    w_last_op_nxt = r_last_op;
    if (w_write) begin
      w_last_op_nxt = OP_WRITE;
    end else if (w_fetch) begin
      w_last_op_nxt = OP_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_op <= OP_FETCH;
    end else begin
      r_last_op <= w_last_op_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_mem_cnt <= r_mem_cnt + 1'b1;
      end
      if (w_fetch) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_mem_cnt   <= r_mem_cnt - 1'b1;
        r_out_data  <= mem_data_out;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign mem_wen     = w_write;
  assign mem_addr    = w_write ? r_wr_ptr : r_rd_ptr;
  assign mem_data_in = in_data;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign count       = r_mem_cnt + {{ADDR_BITS{1'b0}}, r_out_valid};
  assign full        = (r_mem_cnt == LP_DEPTH);

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl with a behavioural reg_mem attached.
module tb_mem_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] count;
  logic       full;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_wen;
  logic [7:0] mem_data_out;

  logic [7:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;

  mem_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wen      (mem_wen),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, v, rx, sent, alt_bad, k;
    logic saw_wrap, prev_iv, prev_wen;
    logic [4:0] prev_addr;

    for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b0;

    // reset
    #3;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_mem_wen", mem_wen, 0);
    check_eq("rst_count", count, 0);
    next_cycle(); next_cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_out_valid", out_valid, 0);
    check_eq("post_rst_count", count, 0);
    check_eq("post_rst_full", full, 0);
    check_eq("post_rst_mem_wen", mem_wen, 0);

    // single word latency
    next_cycle();
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    check_eq("sw_c0_wen", mem_wen, 1);
    check_eq("sw_c0_addr", mem_addr, 0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("sw_c1_wen", mem_wen, 0);
    check_eq("sw_c1_addr", mem_addr, 0);
    check_eq("sw_c1_out_valid", out_valid, 0);
    next_cycle();
    @(negedge clk);
    check_eq("sw_c2_out_valid", out_valid, 1);
    check_eq("sw_c2_out_data", out_data, 8'hA5);
    check_eq("sw_c2_count", count, 1);
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("sw_drained", out_valid, 0);

    // fill: offer 0..40, expect 33 accepted
    next_cycle();
    acc = 0; v = 0;
    in_valid = 1'b1; in_data = 8'(v);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin acc++; v++; end
      next_cycle();
      if (v > 40) in_valid = 1'b0;
      else in_data = 8'(v);
    end
    @(negedge clk);
    check_eq("fill_accepted", acc, 33);
    check_eq("fill_full", full, 1);
    check_eq("fill_in_ready", in_ready, 0);
    check_eq("fill_count", count, 33);
    check_eq("fill_head_hold", out_data, 0);
    in_valid = 1'b0;

    // drain with wrap
    next_cycle();
    out_ready = 1'b1;
    rx = 0; saw_wrap = 1'b0; prev_addr = 5'd0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (!mem_wen && prev_addr == 5'd31 && mem_addr == 5'd0) saw_wrap = 1'b1;
      prev_addr = mem_addr;
      if (out_valid && out_ready) begin
        check_eq("drain_order", out_data, 32'(rx));
        rx++;
      end
      next_cycle();
    end
    @(negedge clk);
    check_eq("drain_total", rx, 33);
    check_eq("drain_wrap", saw_wrap, 1);
    check_eq("drain_count", count, 0);
    check_eq("drain_out_valid", out_valid, 0);

    // simultaneous traffic
    next_cycle();
    sent = 0; rx = 0; alt_bad = 0; prev_iv = 1'b0; prev_wen = 1'b0;
    in_valid = 1'b1; in_data = 8'h40;
    for (int c = 0; c < 400 && rx < 100; c++) begin
      @(negedge clk);
      if (in_valid && prev_iv && (mem_wen == prev_wen)) alt_bad++;
      prev_iv = in_valid; prev_wen = mem_wen;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check_eq("sim_order", out_data, 32'h40 + 32'(rx));
        rx++;
      end
      next_cycle();
      if (sent >= 100) in_valid = 1'b0;
      else in_data = 8'(8'h40 + sent);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("sim_received", rx, 100);
    check_eq("sim_sent", sent, 100);
    check_eq("sim_alternate", alt_bad, 0);
    next_cycle(); next_cycle();
    @(negedge clk);
    check_eq("sim_empty", count, 0);

    // reset mid-operation
    out_ready = 1'b0;
    next_cycle();
    k = 0; in_valid = 1'b1; in_data = 8'h10;
    for (int c = 0; c < 40 && k < 10; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) k++;
      next_cycle();
      if (k >= 10) in_valid = 1'b0;
      else in_data = 8'(8'h10 + k);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_count_before", count, 10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_async_count", count, 0);
    check_eq("mid_async_out_valid", out_valid, 0);
    check_eq("mid_async_full", full, 0);
    #1 rst_n = 1'b1;
    next_cycle();
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    check_eq("mid_push_wen", mem_wen, 1);
    check_eq("mid_push_addr", mem_addr, 0);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("mid_first_valid", out_valid, 1);
    check_eq("mid_first_data", out_data, 8'h3C);
    check_eq("mid_first_count", count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_fifo_ctrl.md
MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-002 SHALL have parameter ADDR_BITS, default 5, storage address width; DEPTH = 2^ADDR_BITS (32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  DATA_WIDTH  write word from the producer.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  DATA_WIDTH  head word, registered.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid head word.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port count  output  ADDR_BITS+1  total words held (memory plus output register).
REQ-012 SHALL have port full  output  1  memory holds DEPTH words.
REQ-013 SHALL have port mem_addr  output  ADDR_BITS  address to downstream reg_mem.
REQ-014 SHALL have port mem_data_in  output  DATA_WIDTH  write data to reg_mem.
REQ-015 SHALL have port mem_wen  output  1  write enable to reg_mem.
REQ-016 SHALL have port mem_data_out  input  DATA_WIDTH  reg_mem read data, combinational from mem_addr.

Function
REQ-017 SHALL treat reg_mem as single-port: write at rising clk when mem_wen=1; read data valid same cycle as mem_addr.
REQ-018 SHALL keep wr_ptr, rd_ptr (ADDR_BITS, wrap DEPTH-1 -> 0), mem_cnt (0..DEPTH), last_op (WRITE/FETCH).
REQ-019 SHALL define F = (mem_cnt>0) && (!out_valid || out_ready).
REQ-020 SHALL drive in_ready = (mem_cnt<DEPTH) && !(F && last_op==WRITE).
REQ-021 SHALL perform a WRITE cycle when in_valid && in_ready: mem_wen=1, mem_addr=wr_ptr, mem_data_in=in_data; wr_ptr+1, mem_cnt+1, last_op<=WRITE.
REQ-022 SHALL perform a FETCH cycle when F and no WRITE: mem_wen=0, mem_addr=rd_ptr; out_data<=mem_data_out, out_valid<=1, rd_ptr+1, mem_cnt-1, last_op<=FETCH.
REQ-023 SHALL in an IDLE cycle drive mem_wen=0, mem_addr=rd_ptr, mem_data_in=in_data; last_op unchanged.
REQ-024 SHALL clear out_valid when out_valid && out_ready and no FETCH that cycle.
REQ-025 SHALL, with both pending, alternate grants (round-robin via last_op); no starvation of either side.
REQ-026 SHALL give minimum latency 2 cycles: word accepted cycle N appears with out_valid=1 at cycle N+2 when empty.
REQ-027 SHALL drive count = mem_cnt + out_valid, full = (mem_cnt==DEPTH); max count DEPTH+1 (33).
REQ-028 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-029 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-030 SHALL never write when full; in_valid while full is ignored, no state change.

Reset
REQ-031 SHALL, while rst_n=0, immediately force wr_ptr=rd_ptr=0, mem_cnt=0, last_op=FETCH, out_valid=0, out_data=0, count=0, full=0, mem_wen=0, in_ready=0.
REQ-032 SHALL, on rst_n release, start with in_ready=1 and no stale memory contents visible; reset mid-transfer discards all held words.

Verification
REQ-033 SHALL cover reset: rst_n low then high -> out_valid=0, count=0, full=0, mem_wen=0, in_ready=1.
REQ-034 SHALL cover single word: push 0xA5, out_ready=0 -> cycle0 mem_wen=1 addr0; cycle1 mem_wen=0 addr0; cycle2 out_valid=1, out_data=0xA5, count=1.
REQ-035 SHALL cover fill: out_ready=0, in_valid=1 with values 0..40 -> exactly 33 accepted (0..32), full=1, in_ready=0, count=33.
REQ-036 SHALL cover drain with wrap: after fill, in_valid=0, out_ready=1 -> out_data 0..32 in order, mem_addr wraps 31->0, ends count=0, out_valid=0.
REQ-037 SHALL cover simultaneous traffic: in_valid=1 and out_ready=1 continuous, 100 words -> grants alternate, order preserved, no loss or duplication.
REQ-038 SHALL cover reset mid-operation: count=10, pulse rst_n low between edges -> count=0, out_valid=0 asynchronously; next push 0x3C emerges first.
